dma_io_device: RTL
==================

DMA_IO_DEVICE -- requirements
Module: dma_io_device

Interface
REQ-001 Parameter DEPTH, 4, buffer entries; power of two, 2..16.
REQ-002 Parameter DREQ_ACTIVE_LOW, 0, 1 = DREQ asserted low.
REQ-003 Parameter DACK_ACTIVE_LOW, 0, 1 = DACK sampled active low.
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 EN  in  1  device request enable.
REQ-007 DIR  in  1  1 = source (device->memory, DMA WRITE, IOR strobe); 0 = sink (memory->device, DMA READ, IOW strobe).
REQ-008 DREQ  out  1  DMA request to controller, polarity per DREQ_ACTIVE_LOW.
REQ-009 DACK  in  1  DMA acknowledge, polarity per DACK_ACTIVE_LOW.
REQ-010 IOR_N, IOW_N  in  1 each  active-low I/O strobes.
REQ-011 EOP_N  in  1  active-low terminal count.
REQ-012 DB_IN  in  8  bus data in; DB_OUT  out  8  bus data out; DB_OE  out  1  bus drive enable.
REQ-013 SRC_VALID in 1, SRC_DATA in 8, SRC_READY out 1  local push (source mode).
REQ-014 SNK_VALID out 1, SNK_DATA out 8, SNK_READY in 1  local pop (sink mode).
REQ-015 TC  out  1  sticky terminal-count flag; CLEAR_TC  in  1  clears TC.
REQ-016 ERR  out  1  sticky overrun/underrun flag (see Configuration).

Function
REQ-017 Buffer: DEPTH x 8 FIFO, count 0..DEPTH, pointers wrap modulo DEPTH; simultaneous push and pop leaves count unchanged.
REQ-018 Eligible = EN and (DIR ? count>0 : count<DEPTH).
REQ-019 FSM states IDLE, REQ, ACK, TCS; DIR latched on IDLE->REQ; DIR changes outside IDLE ignored.
REQ-020 IDLE->REQ when Eligible; REQ->IDLE when EN low; REQ->ACK when DACK sampled active.
REQ-021 DREQ registered: active in REQ and ACK while Eligible; asserts one cycle after Eligible rises, deasserts one cycle after Eligible falls (demand mode).
REQ-022 IOR_N/IOW_N registered once; transfer on detected rising edge (prev low, now high) in ACK with DACK active.
REQ-023 Source transfer: pop head on IOR_N rising edge; DB_OUT = FIFO head; DB_OE = state ACK and DACK active and raw IOR_N low and latched DIR=1, combinational.
REQ-024 Sink transfer: DB_IN registered while IOW_N low; on IOW_N rising edge push last registered value.
REQ-025 ACK->TCS when EOP_N sampled low in ACK; transfer on same edge completes; TC set; DREQ inactive next cycle.
REQ-026 ACK->REQ when DACK inactive and Eligible; ACK->IDLE when DACK inactive and not Eligible.
REQ-027 TCS->IDLE when CLEAR_TC high; CLEAR_TC and TC set on same cycle: set wins.
REQ-028 SRC_READY = latched-or-current DIR=1 and count<DEPTH; SNK_VALID = DIR=0 and count>0; SNK_DATA = head.
REQ-029 Local side active in every state, including TCS.

Reset
REQ-030 RESET: state IDLE, count 0, pointers 0, DREQ inactive level, DB_OE 0, DB_OUT 0, TC 0, ERR 0, SRC_READY 0, SNK_VALID 0, strobe registers high.
REQ-031 RESET mid-transfer discards buffer contents and the in-flight transfer.

Configuration
REQ-032 Macro DMA_IO_DEVICE_ERR_EN defined: strobe edge in sink mode with count=DEPTH (overrun, data dropped) or source mode with count=0 (underrun, no pop) sets ERR, cleared by CLEAR_TC.
REQ-033 Macro undefined: same events silently ignored, ERR tied 0.

Verification
REQ-034 DIR=1, EN=1, push 0xA5,0x3C; DACK active, two IOR_N pulses -> DB_OUT 0xA5 then 0x3C while DB_OE; DREQ inactive one cycle after second pop.
REQ-035 DIR=0, DEPTH=4, four IOW_N pulses with DB_IN 0x01..0x04 -> DREQ drops after fourth; SNK_DATA yields 0x01..0x04 in order.
REQ-036 EOP_N low during third of five IOR_N transfers -> TC=1, DREQ inactive, two bytes remain; CLEAR_TC -> REQ re-entered.
REQ-037 With DMA_IO_DEVICE_ERR_EN, fifth IOW_N pulse on full FIFO -> ERR=1, count stays 4; without macro ERR=0.
REQ-038 RESET asserted mid-ACK with count=3 -> outputs at reset values asynchronously, count 0.
REQ-039 DREQ_ACTIVE_LOW=1, DACK_ACTIVE_LOW=1 -> REQ-034 passes with inverted DREQ/DACK levels.

Source files
------------

// File: rtl/dma_io_device.sv
// Single-channel DMA slave with a DEPTH x 8 byte buffer between the bus side and a local stream.
// Optional sticky overrun/underrun flag on ERR when DMA_IO_DEVICE_ERR_EN is defined; otherwise ERR is tied low.
module dma_io_device #(
    parameter int DEPTH           = 4,
    parameter bit DREQ_ACTIVE_LOW = 1'b0,
    parameter bit DACK_ACTIVE_LOW = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       EN,
    input  logic       DIR,
    output logic       DREQ,
    input  logic       DACK,
    input  logic       IOR_N,
    input  logic       IOW_N,
    input  logic       EOP_N,
    input  logic [7:0] DB_IN,
    output logic [7:0] DB_OUT,
    output logic       DB_OE,
    input  logic       SRC_VALID,
    input  logic [7:0] SRC_DATA,
    output logic       SRC_READY,
    output logic       SNK_VALID,
    output logic [7:0] SNK_DATA,
    input  logic       SNK_READY,
    output logic       TC,
    input  logic       CLEAR_TC,
    output logic       ERR
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_TCS} state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            dir_lat, dreq_act, ior_q, iow_q, tc_q;
    logic [7:0]      db_q;

    logic dack_act, eff_dir, full, empty, eligible, xfer_en;
    logic ior_rise, iow_rise, bus_rd, bus_wr, push, pop;
    logic [7:0] push_data;

    // dir_lat follows DIR while idle, so it is the "current" direction there
    // and the frozen one once a request is in progress.
    assign dack_act  = DACK ^ DACK_ACTIVE_LOW;
    assign eff_dir   = (state == S_IDLE) ? DIR : dir_lat;
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign eligible  = EN && (eff_dir ? !empty : !full);
    assign xfer_en   = (state == S_ACK) && dack_act;

    assign ior_rise  = !ior_q && IOR_N;
    assign iow_rise  = !iow_q && IOW_N;
    assign bus_rd    = xfer_en && dir_lat && ior_rise;
    assign bus_wr    = xfer_en && !dir_lat && iow_rise;

    assign push      = dir_lat ? (SRC_VALID && SRC_READY) : (bus_wr && !full);
    assign pop       = dir_lat ? (bus_rd && !empty) : (SNK_VALID && SNK_READY);
    assign push_data = dir_lat ? SRC_DATA : db_q;

    assign SRC_READY = dir_lat && !full;
    assign SNK_VALID = !dir_lat && !empty;
    assign SNK_DATA  = mem[rd_ptr];
    assign DB_OUT    = mem[rd_ptr];
    assign DB_OE     = xfer_en && !IOR_N && dir_lat;
    assign DREQ      = dreq_act ^ DREQ_ACTIVE_LOW;
    assign TC        = tc_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= S_IDLE;
            dir_lat  <= 1'b0;
            dreq_act <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    dir_lat  <= DIR;
                    dreq_act <= eligible;
                    if (eligible) state <= S_REQ;
                end
                S_REQ: begin
                    if (!EN) begin
                        state    <= S_IDLE;
                        dreq_act <= 1'b0;
                    end else begin
                        if (dack_act) state <= S_ACK;
                        dreq_act <= eligible;
                    end
                end
                S_ACK: begin
                    // terminal count wins; the strobe edge on this cycle still transfers
                    if (!EOP_N) begin
                        state    <= S_TCS;
                        dreq_act <= 1'b0;
                    end else begin
                        if (!dack_act) state <= eligible ? S_REQ : S_IDLE;
                        dreq_act <= eligible;
                    end
                end
                S_TCS: begin
                    dreq_act <= 1'b0;
                    if (CLEAR_TC) state <= S_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    dreq_act <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ior_q <= 1'b1;
            iow_q <= 1'b1;
            db_q  <= '0;
            tc_q  <= 1'b0;
        end else begin
            ior_q <= IOR_N;
            iow_q <= IOW_N;
            if (!IOW_N) db_q <= DB_IN;
            if ((state == S_ACK) && !EOP_N) tc_q <= 1'b1;
            else if (CLEAR_TC)              tc_q <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef DMA_IO_DEVICE_ERR_EN
    logic err_q, underrun, overrun;
    assign underrun = bus_rd && empty;
    assign overrun  = bus_wr && full;
    assign ERR      = err_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                    err_q <= 1'b0;
        else if (underrun || overrun) err_q <= 1'b1;
        else if (CLEAR_TC)            err_q <= 1'b0;
    end
`else
    assign ERR = 1'b0;
`endif

endmodule
